wptr_full_lvl: RTL and testbench
================================

Name: wptr_full_lvl

Overview:
- Write-domain pointer and status block for the dual-clock FIFO; next generation of the write-pointer/full generator.
- Keeps binary and Gray write pointers and registered full/almost-full flags. Adds a runtime-programmable almost-full threshold, a registered fill-level output, and sticky overflow detection with a saturating dropped-write counter.
- Sits between the write client and the FIFO RAM; its Gray pointer feeds the read-domain 2-FF synchroniser.

Parameters:
- ADDRSIZE, 4, RAM address width; FIFO depth DEPTH = 2^ADDRSIZE; pointers are ADDRSIZE+1 bits.
- OVF_CNT_W, 8, width of the dropped-write counter.

Ports:
- wclk  in  1  write clock
- wrst_n  in  1  asynchronous active-low reset
- winc  in  1  write request
- wq2_rptr  in  ADDRSIZE+1  read Gray pointer, already synchronised into wclk
- awfull_thresh  in  ADDRSIZE+1  almost-full threshold, in free slots (quasi-static)
- ovf_clr  in  1  clears wovf and wovf_cnt
- wfull  out  1  FIFO full (registered)
- awfull  out  1  free slots <= awfull_thresh (registered)
- waddr  out  ADDRSIZE  RAM write address
- wptr  out  ADDRSIZE+1  write Gray pointer (registered)
- wlevel  out  ADDRSIZE+1  fill level, 0..DEPTH (registered)
- wovf  out  1  sticky overflow flag
- wovf_cnt  out  OVF_CNT_W  dropped-write count, saturating
- rptr_err  out  1  read-pointer sanity error (see Optional Feature)

Behaviour:
- Reset: wrst_n is asynchronous, active-low; clock is wclk. While wrst_n=0: wbin, wptr, wfull, awfull, wlevel, wovf, wovf_cnt and rptr_err = 0. Read side must be reset in the same window.
- Push: push = winc & ~wfull. wbinnext = (wbin + push) mod 2^(ADDRSIZE+1). wgraynext = wbinnext ^ (wbinnext >> 1).
- Pointer registers: wbin <= wbinnext; wptr <= wgraynext. waddr = wbin[ADDRSIZE-1:0] (combinational from the register).
- Read-pointer decode: rbin_s = Gray-to-binary(wq2_rptr), combinational, bitwise XOR-prefix from the MSB.
- Level: lvl_next = (wbinnext - rbin_s) mod 2^(ADDRSIZE+1). wlevel <= lvl_next.
- Full: wfull <= (lvl_next == DEPTH). This is identical to the Gray test wgraynext == {~wq2_rptr[MSB:MSB-1], wq2_rptr[MSB-2:0]}.
- Almost-full: awfull <= ((DEPTH - lvl_next) <= awfull_thresh).
  - awfull_thresh = 0 makes awfull equal to wfull.
  - awfull_thresh >= DEPTH makes awfull 1 from the first clock after reset.
- Latency: one wclk from an accepted winc to the updated wptr, wlevel and flags. Flags are pessimistic: the read pointer lags by the synchroniser delay, so level is never underestimated and full deasserts 2-3 wclk after the actual read.
- Wrap: pointers wrap mod 2^(ADDRSIZE+1); the MSB distinguishes full from empty when address bits match.
- Overflow: ovf_ev = winc & wfull. The write is dropped; wbin and wptr are unchanged.
  - ovf_ev sets wovf to 1 (sticky).
  - ovf_ev increments wovf_cnt, saturating at all-ones.
- Clear: ovf_clr alone sets wovf=0 and wovf_cnt=0. If ovf_clr and ovf_ev occur in the same cycle: wovf=1, wovf_cnt=1.
- Threshold change: takes effect on the next clock edge; no glitch suppression.

Optional Feature:
- Macro: WPTR_RPTR_CHECK_EN
- Defined:
  - Register the previous wq2_rptr (reset value 0).
  - rptr_err is set sticky, cleared only by reset, if either condition holds in a cycle:
    - more than one bit differs between the previous and current wq2_rptr;
    - (wbin - rbin_s) mod 2^(ADDRSIZE+1) > DEPTH, meaning the read pointer is ahead of the write pointer.
- Not defined: rptr_err is tied to 0 and no check logic is built.

Test Plan:
- ADDRSIZE=4, thresh=2, wq2_rptr=0: 16 consecutive winc.
  - wlevel counts 1..16.
  - awfull asserts the cycle wlevel reaches 14.
  - wfull asserts the cycle wlevel reaches 16.
  - wptr sequence follows Gray 00001,00011,...,11000.
- Full, then 3 extra winc: wbin stays 16, wovf=1, wovf_cnt=3. ovf_clr with a 4th winc in the same cycle gives wovf=1, wovf_cnt=1.
- Full, then set wq2_rptr to Gray(1)=00001: the next cycle gives wfull=0, wlevel=15. One winc then returns wfull=1.
- Wrap: write 40 and read-advance 40 in lockstep (wq2_rptr tracks wptr 2 cycles late). Pointers wrap at 32, wfull never asserts, wlevel stays <=2.
- Set OVF_CNT_W=2 and issue 5 overflow writes: wovf_cnt saturates at 3. Assert wrst_n=0 mid-burst: all outputs 0 asynchronously.
- With WPTR_RPTR_CHECK_EN defined, step wq2_rptr 00000 -> 00011 in one cycle: rptr_err=1 and stays 1 until reset. Without the macro, rptr_err stays 0.

Source files
------------

// File: rtl/wptr_full_lvl.sv
// Write-domain pointer/status block for the dual-clock FIFO: binary+Gray write pointer,
// registered full/almost-full/level, sticky overflow with saturating drop counter.
// Optional read-pointer sanity check is built when WPTR_RPTR_CHECK_EN is defined.
`default_nettype none

module wptr_full_lvl #(
  parameter int ADDRSIZE  = 4,
  parameter int OVF_CNT_W = 8
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  input  logic                 winc,
  input  logic [ADDRSIZE:0]    wq2_rptr,
  input  logic [ADDRSIZE:0]    awfull_thresh,
  input  logic                 ovf_clr,
  output logic                 wfull,
  output logic                 awfull,
  output logic [ADDRSIZE-1:0]  waddr,
  output logic [ADDRSIZE:0]    wptr,
  output logic [ADDRSIZE:0]    wlevel,
  output logic                 wovf,
  output logic [OVF_CNT_W-1:0] wovf_cnt,
  output logic                 rptr_err
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDRSIZE{1'b0}}};
  localparam logic [OVF_CNT_W-1:0] CNT_MAX = {OVF_CNT_W{1'b1}};

  logic [PW-1:0]        r_wbin;
  logic [PW-1:0]        r_wptr;
  logic                 r_wfull;
  logic                 r_awfull;
  logic [PW-1:0]        r_wlevel;
  logic                 r_wovf;
  logic [OVF_CNT_W-1:0] r_wovf_cnt;

  logic                 w_push;
  logic                 w_ovf_ev;
  logic [PW-1:0]        w_wbinnext;
  logic [PW-1:0]        w_wgraynext;
  logic [PW-1:0]        w_rbin_s;
  logic [PW-1:0]        w_lvl_next;
  logic [PW-1:0]        w_free_next;

  assign w_push      = winc & ~r_wfull;
  assign w_ovf_ev    = winc & r_wfull;
  assign w_wbinnext  = r_wbin + {{ADDRSIZE{1'b0}}, w_push};
  assign w_wgraynext = w_wbinnext ^ (w_wbinnext >> 1);

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  genvar gi;
  for (gi = 0; gi < PW; gi++) begin : g_g2b
    assign w_rbin_s[gi] = ^wq2_rptr[PW-1:gi];
  end

  // Level uses the lagging synchronised read pointer, so it never underestimates.
  assign w_lvl_next  = w_wbinnext - w_rbin_s;
  assign w_free_next = DEPTH - w_lvl_next;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wbin   <= '0;
      r_wptr   <= '0;
      r_wfull  <= 1'b0;
      r_awfull <= 1'b0;
      r_wlevel <= '0;
    end else begin
      r_wbin   <= w_wbinnext;
      r_wptr   <= w_wgraynext;
      r_wfull  <= (w_lvl_next == DEPTH);
      r_awfull <= (w_free_next <= awfull_thresh);
      r_wlevel <= w_lvl_next;
    end
  end

  // A clear coinciding with a dropped write still records that write.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wovf     <= 1'b0;
      r_wovf_cnt <= '0;
    end else if (ovf_clr) begin
      r_wovf     <= w_ovf_ev;
      r_wovf_cnt <= w_ovf_ev ? OVF_CNT_W'(1) : '0;
    end else if (w_ovf_ev) begin
      r_wovf <= 1'b1;
      if (r_wovf_cnt != CNT_MAX)
        r_wovf_cnt <= r_wovf_cnt + OVF_CNT_W'(1);
    end
  end

`ifdef WPTR_RPTR_CHECK_EN
  logic [PW-1:0] r_rptr_prev;
  logic          r_rptr_err;
  logic [PW-1:0] w_rptr_diff;
  logic [PW-1:0] w_wr_lead;
  logic          w_multi_bit;
  logic          w_rd_ahead;

  // A legal synchronised Gray pointer changes at most one bit per write clock.
  assign w_rptr_diff = r_rptr_prev ^ wq2_rptr;
  assign w_multi_bit = (w_rptr_diff & (w_rptr_diff - PW'(1))) != '0;
  assign w_wr_lead   = r_wbin - w_rbin_s;
  assign w_rd_ahead  = w_wr_lead > DEPTH;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_rptr_prev <= '0;
      r_rptr_err  <= 1'b0;
    end else begin
      r_rptr_prev <= wq2_rptr;
      if (w_multi_bit || w_rd_ahead)
        r_rptr_err <= 1'b1;
    end
  end

  assign rptr_err = r_rptr_err;
`else
  assign rptr_err = 1'b0;
`endif

  assign wfull    = r_wfull;
  assign awfull   = r_awfull;
  assign waddr    = r_wbin[ADDRSIZE-1:0];
  assign wptr     = r_wptr;
  assign wlevel   = r_wlevel;
  assign wovf     = r_wovf;
  assign wovf_cnt = r_wovf_cnt;

endmodule

`default_nettype wire

// File: tb/tb_wptr_full_lvl.sv
// Scoreboard bench for wptr_full_lvl: directed steps push expected state, a negedge
// monitor pops and compares. A second instance with a 2-bit drop counter shares inputs.
`timescale 1ns/1ps

module tb_wptr_full_lvl;

`ifdef WPTR_RPTR_CHECK_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  typedef struct packed {
    logic       full;
    logic       afull;
    logic [3:0] addr;
    logic [4:0] ptr;
    logic [4:0] lvl;
    logic       ovf;
    logic [7:0] cnt;
    logic [1:0] cnt2;
    logic       err;
  } st_t;

  typedef struct {
    string nm;
    st_t   s;
  } exp_t;

  logic       wclk, wrst_n, winc, ovf_clr;
  logic [4:0] wq2_rptr, awfull_thresh;
  logic       wfull, awfull, wovf, rptr_err;
  logic [3:0] waddr;
  logic [4:0] wptr, wlevel;
  logic [7:0] wovf_cnt;
  logic       wfull2, awfull2, wovf2, rptr_err2;
  logic [3:0] waddr2;
  logic [4:0] wptr2, wlevel2;
  logic [1:0] wovf_cnt2;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  wptr_full_lvl #(.ADDRSIZE(4), .OVF_CNT_W(8)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wq2_rptr(wq2_rptr),
    .awfull_thresh(awfull_thresh), .ovf_clr(ovf_clr), .wfull(wfull),
    .awfull(awfull), .waddr(waddr), .wptr(wptr), .wlevel(wlevel),
    .wovf(wovf), .wovf_cnt(wovf_cnt), .rptr_err(rptr_err)
  );

  wptr_full_lvl #(.ADDRSIZE(4), .OVF_CNT_W(2)) dut2 (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wq2_rptr(wq2_rptr),
    .awfull_thresh(awfull_thresh), .ovf_clr(ovf_clr), .wfull(wfull2),
    .awfull(awfull2), .waddr(waddr2), .wptr(wptr2), .wlevel(wlevel2),
    .wovf(wovf2), .wovf_cnt(wovf_cnt2), .rptr_err(rptr_err2)
  );

  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  function automatic logic [4:0] g(input int v);
    logic [4:0] b;
    b = 5'(v);
    return b ^ (b >> 1);
  endfunction

  function automatic st_t mk(input logic full, input logic afull, input int addr,
                             input logic [4:0] ptr, input int lvl, input logic ovf,
                             input int cnt, input int cnt2, input logic err);
    st_t s;
    s.full  = full;
    s.afull = afull;
    s.addr  = 4'(addr);
    s.ptr   = ptr;
    s.lvl   = 5'(lvl);
    s.ovf   = ovf;
    s.cnt   = 8'(cnt);
    s.cnt2  = 2'(cnt2);
    s.err   = err;
    return s;
  endfunction

  // Drive one cycle's inputs, then queue the state expected after that edge.
  task automatic step(input logic w, input logic [4:0] rp, input logic [4:0] th,
                      input logic clr, input string nm, input st_t e);
    exp_t x;
    @(negedge wclk);
    winc = w; wq2_rptr = rp; awfull_thresh = th; ovf_clr = clr;
    @(posedge wclk);
    #1;
    x.nm = nm; x.s = e;
    q.push_back(x);
  endtask

  task automatic push_zero(input string nm);
    exp_t x;
    x.nm = nm; x.s = '0;
    q.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge wclk);
    wrst_n = 1'b0; winc = 1'b0; wq2_rptr = '0; ovf_clr = 1'b0; awfull_thresh = 5'd2;
    @(posedge wclk);
    #1 push_zero("reset");
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  // Monitor: compares the DUT state against the oldest queued expectation.
  initial begin
    exp_t x;
    st_t  got;
    forever begin
      @(negedge wclk);
      if (q.size() != 0) begin
        x = q.pop_front();
        got = {wfull, awfull, waddr, wptr, wlevel, wovf, wovf_cnt, wovf_cnt2, rptr_err};
        checks++;
        if (got !== x.s) begin
          errors++;
          $display("FAIL %s: got full=%b afull=%b addr=%0d ptr=%b lvl=%0d ovf=%b cnt=%0d cnt2=%0d err=%b; expected full=%b afull=%b addr=%0d ptr=%b lvl=%0d ovf=%b cnt=%0d cnt2=%0d err=%b",
                   x.nm, got.full, got.afull, got.addr, got.ptr, got.lvl, got.ovf, got.cnt, got.cnt2, got.err,
                   x.s.full, x.s.afull, x.s.addr, x.s.ptr, x.s.lvl, x.s.ovf, x.s.cnt, x.s.cnt2, x.s.err);
        end
      end
    end
  end

  initial begin
    wrst_n = 1'b0; winc = 1'b0; wq2_rptr = '0; awfull_thresh = 5'd2; ovf_clr = 1'b0;
    repeat (2) @(posedge wclk);
    do_reset();

    // Threshold at DEPTH: almost-full on the first edge out of reset.
    step(0, 5'd0, 5'd16, 0, "thresh_depth", mk(0, 1, 0, 5'd0, 0, 0, 0, 0, 0));
    step(0, 5'd0, 5'd2,  0, "thresh_back",  mk(0, 0, 0, 5'd0, 0, 0, 0, 0, 0));

    for (int i = 1; i <= 16; i++)
      step(1, 5'd0, 5'd2, 0, "fill", mk(i == 16, i >= 14, i % 16, g(i), i, 0, 0, 0, 0));

    for (int k = 1; k <= 3; k++)
      step(1, 5'd0, 5'd2, 0, "ovf", mk(1, 1, 0, 5'b11000, 16, 1, k, k, 0));
    step(1, 5'd0, 5'd2, 1, "clr_with_ovf", mk(1, 1, 0, 5'b11000, 16, 1, 1, 1, 0));
    step(0, 5'd0, 5'd2, 1, "clr_alone",    mk(1, 1, 0, 5'b11000, 16, 0, 0, 0, 0));

    for (int k = 1; k <= 5; k++)
      step(1, 5'd0, 5'd2, 0, "ovf_sat", mk(1, 1, 0, 5'b11000, 16, 1, k, (k > 3) ? 3 : k, 0));
    step(0, 5'd0, 5'd2, 1, "clr_sat", mk(1, 1, 0, 5'b11000, 16, 0, 0, 0, 0));

    // Read side frees one slot, then a write refills it.
    step(0, 5'b00001, 5'd2, 0, "rd_one",   mk(0, 1, 0, 5'b11000, 15, 0, 0, 0, 0));
    step(1, 5'b00001, 5'd2, 0, "refill",   mk(1, 1, 1, 5'b11001, 16, 0, 0, 0, 0));
    step(0, 5'b00001, 5'd0, 0, "thr0_full", mk(1, 1, 1, 5'b11001, 16, 0, 0, 0, 0));
    step(0, 5'b00011, 5'd0, 0, "thr0_free1", mk(0, 0, 1, 5'b11001, 15, 0, 0, 0, 0));
    step(0, 5'b00011, 5'd1, 0, "thr1_free1", mk(0, 1, 1, 5'b11001, 15, 0, 0, 0, 0));
    step(1, 5'b00011, 5'd2, 0, "refill2",  mk(1, 1, 2, 5'b11011, 16, 0, 0, 0, 0));
    step(1, 5'b00011, 5'd2, 0, "ovf_pre_rst", mk(1, 1, 2, 5'b11011, 16, 1, 1, 1, 0));

    // Reset asserted mid-cycle during an overflow burst; no edge before the check.
    @(negedge wclk);
    winc = 1'b1;
    @(posedge wclk);
    #2 wrst_n = 1'b0;
    #1 push_zero("async_rst");
    @(negedge wclk);
    @(posedge wclk);
    #1 push_zero("rst_hold");
    @(negedge wclk);
    winc = 1'b0; wq2_rptr = '0; awfull_thresh = 5'd2; ovf_clr = 1'b0;
    wrst_n = 1'b1;

    // Lockstep write/read across two pointer wraps.
    for (int k = 0; k < 40; k++)
      step(1, (k == 0) ? 5'd0 : g((k - 1) % 32), 5'd2, 0, "wrap",
           mk(0, 0, (k + 1) % 16, g((k + 1) % 32), (k == 0) ? 1 : 2, 0, 0, 0, 0));

    // Illegal two-bit jump of the synchronised read pointer.
    do_reset();
    step(0, 5'b00000, 5'd2, 0, "err_idle", mk(0, 0, 0, 5'd0, 0,  0, 0, 0, 0));
    step(0, 5'b00011, 5'd2, 0, "err_jump", mk(0, 0, 0, 5'd0, 30, 0, 0, 0, ERR));
    step(0, 5'b00000, 5'd2, 0, "err_hold", mk(0, 0, 0, 5'd0, 0,  0, 0, 0, ERR));
    step(0, 5'b00000, 5'd2, 0, "err_stay", mk(0, 0, 0, 5'd0, 0,  0, 0, 0, ERR));
    do_reset();
    step(0, 5'b00000, 5'd2, 0, "err_cleared", mk(0, 0, 0, 5'd0, 0, 0, 0, 0, 0));

    for (int t = 0; t < 10 && q.size() != 0; t++)
      @(negedge wclk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations still pending, expected 0", q.size());
    end
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
